// File: rtl/pwm_meas_scheduler_pkg.sv
// Shared definitions for the PWM measurement scheduler: FSM encoding,
// count width, saturation constant and a saturating adder.
package pwm_meas_scheduler_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEAS_HIGH = 3'd3,
    ST_MEAS_LOW  = 3'd4,
    ST_STORE     = 3'd5,
    ST_NEXT      = 3'd6
  } state_e;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? CNT_SAT : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_meas_scheduler_phase_counter.sv
// Saturating phase counter shared by all channels. A clear that coincides
// with an enable loads 1 so the cycle of the triggering edge is counted.
module pwm_phase_counter
  import pwm_meas_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = en ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign expired = (32'(cnt_q) >= TIMEOUT);

endmodule

// File: rtl/pwm_meas_scheduler.sv
// Round-robin PWM duty/period measurement over NUM_CH asynchronous inputs,
// one channel at a time, with per-phase timeout and per-channel result store.
module pwm_meas_scheduler
  import pwm_meas_scheduler_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       SIGNAL,
  input  logic [NUM_CH-1:0]       enable,
  output logic [16*NUM_CH-1:0]    dty,
  output logic [16*NUM_CH-1:0]    period,
  output logic [NUM_CH-1:0]       valid,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       level,
  output logic [3:0]              cur_ch
);

  state_e state_q, state_d;
  logic [3:0]       cur_ch_q, cur_ch_d;
  logic             settle_q, settle_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] prev_q, prev_d;

  logic [15:0] sync_ext, prev_ext, en_ext;
  logic        sig, rise, fall, en_cur;
  logic [3:0]  lowest_ch, next_ch, cand;
  logic        found;

  logic             cnt_clr, cnt_en, cnt_expired;
  logic [CNT_W-1:0] cnt;
  logic             store_wr, abort_wr;

  // Third stage (prev) only serves edge detection on the synchronized level.
  always_comb begin
    sync1_d = SIGNAL;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Zero-extend to 16 so a 4-bit channel index never selects out of range.
  always_comb begin
    sync_ext = '0;
    prev_ext = '0;
    en_ext   = '0;
    sync_ext[NUM_CH-1:0] = sync2_q;
    prev_ext[NUM_CH-1:0] = prev_q;
    en_ext[NUM_CH-1:0]   = enable;
  end

  assign sig    = sync_ext[cur_ch_q];
  assign rise   = sig & ~prev_ext[cur_ch_q];
  assign fall   = ~sig & prev_ext[cur_ch_q];
  assign en_cur = en_ext[cur_ch_q];

  always_comb begin
    lowest_ch = '0;
    for (int i = 15; i >= 0; i--) begin
      if (en_ext[i]) lowest_ch = 4'(i);
    end
    next_ch = cur_ch_q;
    found   = 1'b0;
    cand    = '0;
    // Offset 16 wraps back onto cur_ch itself, covering the single-channel case.
    for (int off = 1; off <= 16; off++) begin
      cand = cur_ch_q + 4'(off);
      if (!found && en_ext[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  pwm_phase_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (cnt),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    settle_d = 1'b0;
    high_d   = high_q;
    low_d    = low_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    store_wr = 1'b0;
    abort_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|enable) begin
          cur_ch_d = lowest_ch;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!en_cur) begin
          state_d = ST_NEXT;
        end else if (settle_q) begin
          state_d = ST_WAIT_RISE;
          cnt_clr = 1'b1;
        end else begin
          settle_d = 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        cnt_en = 1'b1;
        if (!en_cur) begin
          state_d = ST_NEXT;
        end else if (rise) begin
          cnt_clr = 1'b1;
          state_d = ST_MEAS_HIGH;
        end else if (cnt_expired) begin
          abort_wr = 1'b1;
          state_d  = ST_NEXT;
        end
      end
      ST_MEAS_HIGH: begin
        cnt_en = 1'b1;
        if (!en_cur) begin
          state_d = ST_NEXT;
        end else if (fall) begin
          high_d  = cnt;
          cnt_clr = 1'b1;
          state_d = ST_MEAS_LOW;
        end else if (cnt_expired) begin
          abort_wr = 1'b1;
          state_d  = ST_NEXT;
        end
      end
      ST_MEAS_LOW: begin
        cnt_en = 1'b1;
        if (!en_cur) begin
          state_d = ST_NEXT;
        end else if (rise) begin
          low_d   = cnt;
          state_d = ST_STORE;
        end else if (cnt_expired) begin
          abort_wr = 1'b1;
          state_d  = ST_NEXT;
        end
      end
      ST_STORE: begin
        store_wr = en_cur;
        state_d  = ST_NEXT;
      end
      ST_NEXT: begin
        if (enable == '0) begin
          state_d = ST_IDLE;
        end else begin
          cur_ch_d = next_ch;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_ch_q <= '0;
      settle_q <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      settle_q <= settle_d;
      high_q   <= high_d;
      low_q    <= low_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] dty_q, dty_d, period_q, period_d;
      logic             valid_q, valid_d, timeout_q, timeout_d, level_q, level_d;
      logic             hit;

      assign hit = (cur_ch_q == 4'(gi));

      always_comb begin
        dty_d     = dty_q;
        period_d  = period_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        level_d   = level_q;
        if (hit && store_wr) begin
          dty_d     = high_q;
          period_d  = sat_add(high_q, low_q);
          valid_d   = 1'b1;
          timeout_d = 1'b0;
        end else if (hit && abort_wr) begin
          dty_d     = '0;
          period_d  = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          level_d   = sig;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dty_q     <= '0;
          period_q  <= '0;
          valid_q   <= 1'b0;
          timeout_q <= 1'b0;
          level_q   <= 1'b0;
        end else begin
          dty_q     <= dty_d;
          period_q  <= period_d;
          valid_q   <= valid_d;
          timeout_q <= timeout_d;
          level_q   <= level_d;
        end
      end

      assign dty[16*gi +: 16]    = dty_q;
      assign period[16*gi +: 16] = period_q;
      assign valid[gi]           = valid_q;
      assign timeout[gi]         = timeout_q;
      assign level[gi]           = level_q;
    end
  endgenerate

  assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_pwm_meas_scheduler.sv
// Scoreboard bench: two instances (default TIMEOUT and TIMEOUT=50) share the
// PWM stimulus; expected per-channel results are queued and popped on update.
module tb_pwm_meas_scheduler;

  localparam int NCH = 4;

  logic clk;
  logic rst_n;
  logic [NCH-1:0] signal_r;
  logic [NCH-1:0] enable_m, enable_t;

  logic [16*NCH-1:0] dty_m, period_m, dty_t, period_t;
  logic [NCH-1:0]    valid_m, timeout_m, level_m, valid_t, timeout_t, level_t;
  logic [3:0]        cur_ch_m, cur_ch_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_meas_scheduler #(.NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .SIGNAL(signal_r), .enable(enable_m),
    .dty(dty_m), .period(period_m), .valid(valid_m), .timeout(timeout_m),
    .level(level_m), .cur_ch(cur_ch_m)
  );

  pwm_meas_scheduler #(.NUM_CH(NCH), .TIMEOUT(50)) dut_to (
    .clk(clk), .rst_n(rst_n), .SIGNAL(signal_r), .enable(enable_t),
    .dty(dty_t), .period(period_t), .valid(valid_t), .timeout(timeout_t),
    .level(level_t), .cur_ch(cur_ch_t)
  );

  typedef struct {
    int          ch;
    logic [15:0] dty;
    logic [15:0] per;
    logic        v;
    logic        to;
    logic        lv;
  } exp_t;

  exp_t sb[$];
  logic [3:0] chlog[$];
  int vectors = 0;
  int miscompares = 0;

  // PWM generator: mode 0 = hi/lo waveform, 1 = stuck high, 2 = stuck low
  int gen_hi[NCH];
  int gen_lo[NCH];
  int gen_mode[NCH];
  int gen_cnt[NCH];

  initial begin
    signal_r = '0;
    for (int c = 0; c < NCH; c++) begin
      gen_mode[c] = 2; gen_hi[c] = 1; gen_lo[c] = 1; gen_cnt[c] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (gen_mode[c] == 1) signal_r[c] = 1'b1;
        else if (gen_mode[c] == 2) signal_r[c] = 1'b0;
        else begin
          gen_cnt[c]++;
          if (signal_r[c] && gen_cnt[c] >= gen_hi[c]) begin
            signal_r[c] = 1'b0; gen_cnt[c] = 0;
          end else if (!signal_r[c] && gen_cnt[c] >= gen_lo[c]) begin
            signal_r[c] = 1'b1; gen_cnt[c] = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] last;
    last = 4'd0;
    forever begin
      @(negedge clk);
      if (cur_ch_m !== last) begin
        chlog.push_back(cur_ch_m);
        last = cur_ch_m;
      end
    end
  end

  task automatic set_pwm(input int ch, input int hi, input int lo);
    gen_hi[ch] = hi; gen_lo[ch] = lo; gen_cnt[ch] = 0;
    gen_mode[ch] = 0; signal_r[ch] = 1'b0;
  endtask

  task automatic set_stuck(input int ch, input logic v);
    gen_mode[ch] = v ? 1 : 2; signal_r[ch] = v;
  endtask

  function automatic logic [34:0] obs(input bit which, input int ch);
    if (which)
      return {dty_t[16*ch +: 16], period_t[16*ch +: 16], valid_t[ch], timeout_t[ch], level_t[ch]};
    return {dty_m[16*ch +: 16], period_m[16*ch +: 16], valid_m[ch], timeout_m[ch], level_m[ch]};
  endfunction

  function automatic logic [34:0] pack_exp(input exp_t e);
    return {e.dty, e.per, e.v, e.to, e.lv};
  endfunction

  task automatic push_exp(input int ch, input int d, input int p, input logic v,
                          input logic to, input logic lv);
    exp_t e;
    e.ch = ch; e.dty = 16'(d); e.per = 16'(p); e.v = v; e.to = to; e.lv = lv;
    sb.push_back(e);
  endtask

  task automatic wait_result(input bit which, input int ch, input int budget, output bit ok);
    logic [34:0] snap;
    snap = obs(which, ch);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs(which, ch) !== snap) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable_m = '0; enable_t = '0;
    repeat (2) @(negedge clk);
    vectors++; if (dty_m !== '0) begin miscompares++; $display("FAIL reset_dty got=%h want=0", dty_m); end
    vectors++; if (period_m !== '0) begin miscompares++; $display("FAIL reset_period got=%h want=0", period_m); end
    vectors++; if (valid_m !== '0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", valid_m); end
    vectors++; if (timeout_m !== '0) begin miscompares++; $display("FAIL reset_timeout got=%b want=0", timeout_m); end
    vectors++; if (level_m !== '0) begin miscompares++; $display("FAIL reset_level got=%b want=0", level_m); end
    vectors++; if (cur_ch_m !== 4'd0) begin miscompares++; $display("FAIL reset_cur_ch got=%0d want=0", cur_ch_m); end
    $display("reset state checked");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t e; bit ok;
    enable_m = '0; do_reset();
    set_pwm(0, 100, 100);
    push_exp(0, 100, 200, 1'b1, 1'b0, 1'b0);
    enable_m = 4'b0001;
    for (int r = 0; r < 2; r++) begin
      wait_result(1'b0, 0, 2000, ok);
      e = sb.pop_front(); vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_r%0d: no result, got=%h want=%h", r, obs(1'b0, e.ch), pack_exp(e)); end
      else if (obs(1'b0, e.ch) !== pack_exp(e)) begin miscompares++; $display("FAIL single_r%0d got=%h want=%h", r, obs(1'b0, e.ch), pack_exp(e)); end
      else $display("single ch%0d dty=%0d period=%0d valid=%0d", e.ch, e.dty, e.per, e.v);
      if (r == 0) begin
        set_pwm(0, 40, 60);
        push_exp(0, 40, 100, 1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_two_channels();
    exp_t e; bit ok; logic [3:0] want_seq [2];
    enable_m = '0; do_reset();
    set_pwm(0, 30, 70);
    set_pwm(1, 60, 20);
    chlog.delete();
    vectors++; if (cur_ch_m !== 4'd0) begin miscompares++; $display("FAIL two_start_cur_ch got=%0d want=0", cur_ch_m); end
    push_exp(0, 30, 100, 1'b1, 1'b0, 1'b0);
    push_exp(1, 60, 80, 1'b1, 1'b0, 1'b0);
    enable_m = 4'b0011;
    for (int r = 0; r < 2; r++) begin
      wait_result(1'b0, sb[0].ch, 1000, ok);
      e = sb.pop_front(); vectors++;
      if (!ok) begin miscompares++; $display("FAIL two_ch%0d: no result, got=%h want=%h", e.ch, obs(1'b0, e.ch), pack_exp(e)); end
      else if (obs(1'b0, e.ch) !== pack_exp(e)) begin miscompares++; $display("FAIL two_ch%0d got=%h want=%h", e.ch, obs(1'b0, e.ch), pack_exp(e)); end
      else $display("two ch%0d dty=%0d period=%0d", e.ch, e.dty, e.per);
    end
    for (int i = 0; i < 500 && chlog.size() < 2; i++) @(negedge clk);
    want_seq[0] = 4'd1; want_seq[1] = 4'd0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (chlog.size() <= i) begin miscompares++; $display("FAIL two_cur_seq%0d got=none want=%0d", i, want_seq[i]); end
      else if (chlog[i] !== want_seq[i]) begin miscompares++; $display("FAIL two_cur_seq%0d got=%0d want=%0d", i, chlog[i], want_seq[i]); end
      else $display("cur_ch step %0d = %0d", i + 1, chlog[i]);
    end
    enable_m = 4'b0010;
    repeat (200) @(negedge clk);
    push_exp(0, 30, 100, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); vectors++;
    if (obs(1'b0, 0) !== pack_exp(e)) begin miscompares++; $display("FAIL hold_ch0 got=%h want=%h", obs(1'b0, 0), pack_exp(e)); end
    else $display("disabled ch0 held dty=%0d period=%0d", e.dty, e.per);
  endtask

  task automatic test_timeout();
    exp_t e; bit ok;
    enable_m = '0; enable_t = '0; do_reset();
    set_stuck(1, 1'b0);
    set_stuck(2, 1'b1);
    set_pwm(3, 10, 10);
    push_exp(1, 0, 0, 1'b0, 1'b1, 1'b0);
    push_exp(2, 0, 0, 1'b0, 1'b1, 1'b1);
    push_exp(3, 10, 20, 1'b1, 1'b0, 1'b0);
    enable_t = 4'b1110;
    for (int r = 0; r < 3; r++) begin
      wait_result(1'b1, sb[0].ch, 400, ok);
      e = sb.pop_front(); vectors++;
      if (!ok) begin miscompares++; $display("FAIL tmo_ch%0d: no result, got=%h want=%h", e.ch, obs(1'b1, e.ch), pack_exp(e)); end
      else if (obs(1'b1, e.ch) !== pack_exp(e)) begin miscompares++; $display("FAIL tmo_ch%0d got=%h want=%h", e.ch, obs(1'b1, e.ch), pack_exp(e)); end
      else $display("tmo ch%0d valid=%0d timeout=%0d level=%0d dty=%0d", e.ch, e.v, e.to, e.lv, e.dty);
    end
    enable_t = '0;
  endtask

  task automatic test_enable_drop();
    exp_t e; bit ok; bit seen;
    enable_m = '0; do_reset();
    set_pwm(1, 50, 50);
    set_pwm(2, 20, 20);
    enable_m = 4'b0110;
    repeat (130) @(negedge clk);
    enable_m = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (cur_ch_m === 4'd2) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL drop_next_ch got=%0d want=2", cur_ch_m); end
    else $display("drop: moved to ch2");
    push_exp(2, 20, 40, 1'b1, 1'b0, 1'b0);
    wait_result(1'b0, 2, 400, ok);
    e = sb.pop_front(); vectors++;
    if (!ok) begin miscompares++; $display("FAIL drop_ch2: no result, got=%h want=%h", obs(1'b0, 2), pack_exp(e)); end
    else if (obs(1'b0, 2) !== pack_exp(e)) begin miscompares++; $display("FAIL drop_ch2 got=%h want=%h", obs(1'b0, 2), pack_exp(e)); end
    else $display("drop ch2 dty=%0d period=%0d", e.dty, e.per);
    push_exp(1, 0, 0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); vectors++;
    if (obs(1'b0, 1) !== pack_exp(e)) begin miscompares++; $display("FAIL drop_ch1_nowrite got=%h want=%h", obs(1'b0, 1), pack_exp(e)); end
    else $display("drop ch1 left unwritten");
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({dty_m, period_m, valid_m, timeout_m, level_m, cur_ch_m} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got dty=%h period=%h valid=%b cur_ch=%0d want all 0", dty_m, period_m, valid_m, cur_ch_m);
    end else $display("mid-measurement reset cleared outputs");
    repeat (2) @(negedge clk);
    enable_m = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_long_high();
    exp_t e; bit ok;
    enable_m = '0; do_reset();
    set_pwm(0, 70000, 100);
    push_exp(0, 0, 0, 1'b0, 1'b1, 1'b1);
    enable_m = 4'b0001;
    wait_result(1'b0, 0, 70000, ok);
    e = sb.pop_front(); vectors++;
    if (!ok) begin miscompares++; $display("FAIL long_abort: no result, got=%h want=%h", obs(1'b0, 0), pack_exp(e)); end
    else if (obs(1'b0, 0) !== pack_exp(e)) begin miscompares++; $display("FAIL long_abort got=%h want=%h", obs(1'b0, 0), pack_exp(e)); end
    else $display("long high: timeout=%0d level=%0d", e.to, e.lv);
    set_pwm(0, 100, 100);
    push_exp(0, 100, 200, 1'b1, 1'b0, 1'b1);
    wait_result(1'b0, 0, 1000, ok);
    e = sb.pop_front(); vectors++;
    if (!ok) begin miscompares++; $display("FAIL long_recover: no result, got=%h want=%h", obs(1'b0, 0), pack_exp(e)); end
    else if (obs(1'b0, 0) !== pack_exp(e)) begin miscompares++; $display("FAIL long_recover got=%h want=%h", obs(1'b0, 0), pack_exp(e)); end
    else $display("recovered ch0 dty=%0d period=%0d valid=%0d timeout=%0d", e.dty, e.per, e.v, e.to);
  endtask

  initial begin
    rst_n = 1'b0;
    enable_m = '0;
    enable_t = '0;
    test_reset();
    test_single();
    test_two_channels();
    test_timeout();
    test_enable_drop();
    test_long_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
